instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//   MIPS ID stage, directly downstream of instruction fetch. Takes the fetched instr/pc/ce triple and holds the
//   32x32 register file (written by WB). Decodes opcode/funct into control bits, reads rs/rt, sign-extends imm.
//   Resolves J in-stage and redirects fetch. Registers everything into the ID/EX pipeline register (1-cycle latency).
// PARAMETERS
//   PC_WIDTH   32  program counter width
//   IWIDTH     32  instruction width
//   DWIDTH     32  register data width
//   AWIDTH     5   register address width (2**AWIDTH registers)
// PORTS
//   d_clk          in   1         clock, rising edge
//   d_rst          in   1         async reset, active-low
//   d_i_ce         in   1         valid instruction from fetch (fetch f_o_ce)
//   d_i_instr      in   IWIDTH    fetched instruction
//   d_i_pc         in   PC_WIDTH  pc of d_i_instr
//   d_i_stall      in   1         hold ID/EX register and register-file reads
//   d_i_flush      in   1         turn the current slot into a bubble
//   d_i_wb_we      in   1         writeback enable
//   d_i_wb_addr    in   AWIDTH    writeback register
//   d_i_wb_data    in   DWIDTH    writeback data
//   d_o_ce         out  1         ID/EX slot valid
//   d_o_pc         out  PC_WIDTH  pc of decoded instruction
//   d_o_rs_data    out  DWIDTH    rs operand
//   d_o_rt_data    out  DWIDTH    rt operand
//   d_o_imm        out  DWIDTH    sign-extended instr[15:0]
//   d_o_rs_addr    out  AWIDTH    rs field (for forwarding)
//   d_o_rt_addr    out  AWIDTH    rt field
//   d_o_dst_addr   out  AWIDTH    rd for R-type, rt for I-type, 0 otherwise
//   d_o_funct      out  6         funct field (valid for R-type)
//   d_o_ctrl       out  7         {reg_write,mem_read,mem_write,alu_src,branch_eq,branch_ne,rtype}
//   d_o_illegal    out  1         registered: unsupported opcode seen
//   d_o_change_pc  out  1         comb: redirect fetch (J decoded)
//   d_o_pc_target  out  PC_WIDTH  comb: {d_i_pc+4 [31:28], instr[25:0], 2'b00}
// BEHAVIOUR
//   Reset (d_rst=0, async): every registered output 0, all 32 registers 0. Comb outputs 0 while d_i_ce=0.
//   Decode table (opcode -> ctrl):
//     00 R: reg_write, rtype, dst=rd.   08 ADDI: reg_write, alu_src, dst=rt.
//     23 LW: reg_write, mem_read, alu_src, dst=rt.   2B SW: mem_write, alu_src, dst=0.
//     04 BEQ: branch_eq.   05 BNE: branch_ne.   02 J: ctrl=0, d_o_change_pc=1.
//     Other opcodes: ctrl=0, d_o_ce=0, d_o_illegal=1 (sticky until reset).
//   Register file:
//     - Two comb read ports, one write port on posedge d_clk.
//     - Writes to r0 are ignored; reads of r0 return 0.
//     - Write-first bypass: if d_i_wb_we and wb_addr==rs/rt (addr!=0), the read returns d_i_wb_data in the same cycle.
//     - WB writes happen regardless of stall/flush/ce.
//   ID/EX register update, in priority order each posedge:
//     1. d_i_flush=1 -> d_o_ce=0, d_o_ctrl=0, d_o_dst_addr=0. Data fields may hold any value.
//     2. else d_i_stall=1 -> all outputs hold.
//     3. else d_i_ce=1 -> load decoded fields. d_o_ce=1 except for J and illegal (bubble).
//     4. else (d_i_ce=0) -> d_o_ce=0, d_o_ctrl=0.
//     flush+stall together: flush wins.
//   d_o_change_pc is comb on d_i_ce && opcode==02 && !d_i_stall. It is a single-cycle pulse per J.
//   Imm: {{16{instr[15]}}, instr[15:0]}. Target arithmetic is modulo 2**PC_WIDTH (wrap).
//   Latency: decode of instr at edge N appears on outputs after edge N+1. Throughput 1/cycle.
// TESTING
//   1. Reset mid-stream: drive ADDI, assert d_rst=0 -> all outputs 0 immediately; after reset, read r5 -> 0.
//   2. WB r8=0x1234_5678, then ADD rd=9,rs=8,rt=8 -> d_o_rs_data=d_o_rt_data=0x12345678, ctrl=7'b1000001, dst=9.
//   3. Bypass: same cycle wb r3=0xDEAD_BEEF and LW rs=3 imm=0xFFFC -> rs_data=0xDEADBEEF, imm=0xFFFFFFFC, ctrl=7'b1101000.
//   4. Write r0=0xFFFF_FFFF, then read r0 -> 0.
//   5. J 0x0000040 at pc 0x0000_1000 -> change_pc=1 for 1 cycle, target=0x0000_0100; next d_o_ce=0.
//   6. Stall holds for 3 cycles while d_i_instr changes -> outputs unchanged. Flush+stall -> d_o_ce=0.
//      Opcode 0x3F -> d_o_illegal=1, d_o_ce=0.

Source files
------------

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//   MIPS ID stage sitting directly behind instruction fetch. Holds the 32x32
//   register file (written by WB), decodes opcode/funct into control bits,
//   reads rs/rt with write-first bypass, sign-extends the immediate and
//   resolves J in-stage by redirecting fetch. Everything except the fetch
//   redirect is registered into the ID/EX pipeline register (1-cycle latency).
//
// Ports
//   d_clk, d_rst                clock (rising edge), async active-low reset
//   d_i_ce/instr/pc             fetched instruction triple
//   d_i_stall                   hold the ID/EX register
//   d_i_flush                   turn the current slot into a bubble
//   d_i_wb_we/addr/data         register-file write port (from WB)
//   d_o_ce                      ID/EX slot valid
//   d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm
//   d_o_rs_addr, d_o_rt_addr, d_o_dst_addr, d_o_funct
//   d_o_ctrl                    {reg_write,mem_read,mem_write,alu_src,
//                                branch_eq,branch_ne,rtype}
//   d_o_illegal                 sticky: unsupported opcode seen
//   d_o_change_pc, d_o_pc_target  combinational fetch redirect for J
// ---------------------------------------------------------------------------
module instruction_decode #(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                d_i_ce,
    input  logic [IWIDTH-1:0]   d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic                d_i_stall,
    input  logic                d_i_flush,
    input  logic                d_i_wb_we,
    input  logic [AWIDTH-1:0]   d_i_wb_addr,
    input  logic [DWIDTH-1:0]   d_i_wb_data,
    output logic                d_o_ce,
    output logic [PC_WIDTH-1:0] d_o_pc,
    output logic [DWIDTH-1:0]   d_o_rs_data,
    output logic [DWIDTH-1:0]   d_o_rt_data,
    output logic [DWIDTH-1:0]   d_o_imm,
    output logic [AWIDTH-1:0]   d_o_rs_addr,
    output logic [AWIDTH-1:0]   d_o_rt_addr,
    output logic [AWIDTH-1:0]   d_o_dst_addr,
    output logic [5:0]          d_o_funct,
    output logic [6:0]          d_o_ctrl,
    output logic                d_o_illegal,
    output logic                d_o_change_pc,
    output logic [PC_WIDTH-1:0] d_o_pc_target
);

    localparam int NREGS = 2 ** AWIDTH;
    // Bits of pc+4 replaced by the 26-bit jump index (shifted by 2).
    localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'(28'hFFF_FFFF);

    typedef enum logic [5:0] {
        OP_R    = 6'h00,
        OP_J    = 6'h02,
        OP_BEQ  = 6'h04,
        OP_BNE  = 6'h05,
        OP_ADDI = 6'h08,
        OP_LW   = 6'h23,
        OP_SW   = 6'h2B
    } opcode_e;

    // Instruction fields
    logic [5:0]        opcode;
    logic [AWIDTH-1:0] rs_addr;
    logic [AWIDTH-1:0] rt_addr;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] imm_ext;

    assign opcode  = d_i_instr[31:26];
    assign rs_addr = d_i_instr[25:21];
    assign rt_addr = d_i_instr[20:16];
    assign rd_addr = d_i_instr[15:11];
    assign imm_ext = {{(DWIDTH-16){d_i_instr[15]}}, d_i_instr[15:0]};

    // -----------------------------------------------------------------------
    // Register file: two combinational read ports, one write port.
    // -----------------------------------------------------------------------
    logic [DWIDTH-1:0] regs [NREGS];

    // NOTE: the array is reset because the pipeline contract guarantees all
    // registers read as zero after reset; this forces flops instead of RAM.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (d_i_wb_we && d_i_wb_addr != '0) begin
            regs[d_i_wb_addr] <= d_i_wb_data;
        end
    end

    // r0 is hard-wired to zero; a same-cycle WB to the read address wins.
    function automatic logic [DWIDTH-1:0] read_port(input logic [AWIDTH-1:0] addr);
        if (addr == '0)
            return '0;
        else if (d_i_wb_we && d_i_wb_addr == addr)
            return d_i_wb_data;
        else
            return regs[addr];
    endfunction

    logic [DWIDTH-1:0] rs_value;
    logic [DWIDTH-1:0] rt_value;

    assign rs_value = read_port(rs_addr);
    assign rt_value = read_port(rt_addr);

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic [6:0]        dec_ctrl;
    logic [AWIDTH-1:0] dec_dst;
    logic              dec_jump;
    logic              dec_illegal;

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        dec_ctrl    = '0;
        dec_dst     = '0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl = 7'b100_0001;
                dec_dst  = rd_addr;
            end
            OP_ADDI: begin
                dec_ctrl = 7'b100_1000;
                dec_dst  = rt_addr;
            end
            OP_LW: begin
                dec_ctrl = 7'b110_1000;
                dec_dst  = rt_addr;
            end
            OP_SW:   dec_ctrl = 7'b001_1000;
            OP_BEQ:  dec_ctrl = 7'b000_0100;
            OP_BNE:  dec_ctrl = 7'b000_0010;
            OP_J:    dec_jump = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Fetch redirect (combinational). pc+4 wraps modulo 2**PC_WIDTH.
    // -----------------------------------------------------------------------
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] jump_target;

    assign pc_plus4      = d_i_pc + PC_WIDTH'(4);
    assign jump_target   = (pc_plus4 & ~LOW_MASK) | PC_WIDTH'({d_i_instr[25:0], 2'b00});
    assign d_o_pc_target = d_i_ce ? jump_target : '0;
    assign d_o_change_pc = d_i_ce && dec_jump && !d_i_stall;

    // -----------------------------------------------------------------------
    // ID/EX register. Flush beats stall; J and illegal opcodes become bubbles.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            d_o_ce       <= 1'b0;
            d_o_pc       <= '0;
            d_o_rs_data  <= '0;
            d_o_rt_data  <= '0;
            d_o_imm      <= '0;
            d_o_rs_addr  <= '0;
            d_o_rt_addr  <= '0;
            d_o_dst_addr <= '0;
            d_o_funct    <= '0;
            d_o_ctrl     <= '0;
            d_o_illegal  <= 1'b0;
        end else if (d_i_flush) begin
            d_o_ce       <= 1'b0;
            d_o_ctrl     <= '0;
            d_o_dst_addr <= '0;
        end else if (!d_i_stall) begin
            if (d_i_ce) begin
                d_o_ce       <= !(dec_jump || dec_illegal);
                d_o_pc       <= d_i_pc;
                d_o_rs_data  <= rs_value;
                d_o_rt_data  <= rt_value;
                d_o_imm      <= imm_ext;
                d_o_rs_addr  <= rs_addr;
                d_o_rt_addr  <= rt_addr;
                d_o_dst_addr <= dec_dst;
                d_o_funct    <= d_i_instr[5:0];
                d_o_ctrl     <= dec_ctrl;
                if (dec_illegal) begin
                    d_o_illegal <= 1'b1;
                end
            end else begin
                d_o_ce   <= 1'b0;
                d_o_ctrl <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic        d_i_ce = 1'b0;
    logic [31:0] d_i_instr = '0;
    logic [31:0] d_i_pc = '0;
    logic        d_i_stall = 1'b0;
    logic        d_i_flush = 1'b0;
    logic        d_i_wb_we = 1'b0;
    logic [4:0]  d_i_wb_addr = '0;
    logic [31:0] d_i_wb_data = '0;
    logic        d_o_ce;
    logic [31:0] d_o_pc;
    logic [31:0] d_o_rs_data;
    logic [31:0] d_o_rt_data;
    logic [31:0] d_o_imm;
    logic [4:0]  d_o_rs_addr;
    logic [4:0]  d_o_rt_addr;
    logic [4:0]  d_o_dst_addr;
    logic [5:0]  d_o_funct;
    logic [6:0]  d_o_ctrl;
    logic        d_o_illegal;
    logic        d_o_change_pc;
    logic [31:0] d_o_pc_target;

    int checks = 0;
    int errors = 0;

    instruction_decode dut (
        .d_clk        (d_clk),
        .d_rst        (d_rst),
        .d_i_ce       (d_i_ce),
        .d_i_instr    (d_i_instr),
        .d_i_pc       (d_i_pc),
        .d_i_stall    (d_i_stall),
        .d_i_flush    (d_i_flush),
        .d_i_wb_we    (d_i_wb_we),
        .d_i_wb_addr  (d_i_wb_addr),
        .d_i_wb_data  (d_i_wb_data),
        .d_o_ce       (d_o_ce),
        .d_o_pc       (d_o_pc),
        .d_o_rs_data  (d_o_rs_data),
        .d_o_rt_data  (d_o_rt_data),
        .d_o_imm      (d_o_imm),
        .d_o_rs_addr  (d_o_rs_addr),
        .d_o_rt_addr  (d_o_rt_addr),
        .d_o_dst_addr (d_o_dst_addr),
        .d_o_funct    (d_o_funct),
        .d_o_ctrl     (d_o_ctrl),
        .d_o_illegal  (d_o_illegal),
        .d_o_change_pc(d_o_change_pc),
        .d_o_pc_target(d_o_pc_target)
    );

    always #5 d_clk = ~d_clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  dst;
        logic [5:0]  funct;
        logic [6:0]  ctrl;
        logic        illegal;
    } idex_t;

    idex_t       exp_q;
    logic        data_known;   // pc/rs/rt/imm/rsa/rta/funct defined by the rules
    logic        dst_known;
    logic [31:0] mregs [32];

    // Control word straight from the opcode table.
    function automatic logic [6:0] spec_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 7'b1000001;
            6'h08:   return 7'b1001000;
            6'h23:   return 7'b1101000;
            6'h2B:   return 7'b0011000;
            6'h04:   return 7'b0000100;
            6'h05:   return 7'b0000010;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic spec_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (d_i_wb_we && d_i_wb_addr == a) return d_i_wb_data;
        return mregs[a];
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic model_reset;
        exp_q      = '0;
        data_known = 1'b1;
        dst_known  = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    endtask

    task automatic drive(input logic ce, input logic [31:0] instr, pc,
                         input logic stall, flush, we,
                         input logic [4:0] wa, input logic [31:0] wd);
        d_i_ce      = ce;
        d_i_instr   = instr;
        d_i_pc      = pc;
        d_i_stall   = stall;
        d_i_flush   = flush;
        d_i_wb_we   = we;
        d_i_wb_addr = wa;
        d_i_wb_data = wd;
    endtask

    // Advance one clock: predict the ID/EX contents from the current inputs,
    // then apply the WB write to the model register file.
    task automatic tick;
        logic [5:0] op;
        op = d_i_instr[31:26];
        if (d_i_flush) begin
            exp_q.ce   = 1'b0;
            exp_q.ctrl = '0;
            exp_q.dst  = '0;
            dst_known  = 1'b1;
            data_known = 1'b0;
        end else if (d_i_stall) begin
            // everything holds
        end else if (d_i_ce) begin
            exp_q.ce    = spec_legal(op) && op != 6'h02;
            exp_q.pc    = d_i_pc;
            exp_q.rs    = model_read(d_i_instr[25:21]);
            exp_q.rt    = model_read(d_i_instr[20:16]);
            exp_q.imm   = 32'($signed(d_i_instr[15:0]));
            exp_q.rsa   = d_i_instr[25:21];
            exp_q.rta   = d_i_instr[20:16];
            exp_q.funct = d_i_instr[5:0];
            exp_q.ctrl  = spec_ctrl(op);
            exp_q.dst   = (op == 6'h00) ? d_i_instr[15:11] :
                          (op == 6'h08 || op == 6'h23) ? d_i_instr[20:16] : 5'd0;
            if (!spec_legal(op)) exp_q.illegal = 1'b1;
            data_known = 1'b1;
            dst_known  = 1'b1;
        end else begin
            exp_q.ce   = 1'b0;
            exp_q.ctrl = '0;
            data_known = 1'b0;
            dst_known  = 1'b0;
        end
        @(posedge d_clk);
        if (d_i_wb_we && d_i_wb_addr != 0) mregs[d_i_wb_addr] = d_i_wb_data;
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        model_reset();
        idle();
        #2;
        checks++;
        if ({d_o_ce, d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm, d_o_dst_addr, d_o_ctrl,
             d_o_illegal, d_o_change_pc, d_o_pc_target} !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs not all zero (ce=%0b pc=%h ctrl=%b)",
                     d_o_ce, d_o_pc, d_o_ctrl);
        end
        @(negedge d_clk);
        d_rst = 1'b1;
        @(posedge d_clk); #1;
        // load r5, then put an ADDI into ID/EX and reset mid-stream
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAAAA_5555);
        tick();
        drive(1'b1, i_type(6'h08, 5'd5, 5'd6, 16'h0011), 32'h0000_0040, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_ce !== 1'b1 || d_o_rs_data !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL reset_pre_load: ce=%0b rs_data=%h want 1 aaaa5555", d_o_ce, d_o_rs_data);
        end
        d_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({d_o_ce, d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm, d_o_rs_addr, d_o_rt_addr,
             d_o_dst_addr, d_o_funct, d_o_ctrl, d_o_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_async: ce=%0b pc=%h rs=%h imm=%h ctrl=%b want all 0",
                     d_o_ce, d_o_pc, d_o_rs_data, d_o_imm, d_o_ctrl);
        end
        #2;
        d_rst = 1'b1;
        tick();
        drive(1'b1, i_type(6'h08, 5'd5, 5'd5, 16'h0001), 32'h0000_0044, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_rs_data !== 32'h0 || d_o_ce !== 1'b1) begin
            errors++;
            $display("FAIL reset_r5_cleared: rs_data=%h ce=%0b want 0 1", d_o_rs_data, d_o_ce);
        end
    endtask

    task automatic test_rtype;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h1234_5678);
        tick();
        drive(1'b1, r_type(5'd8, 5'd8, 5'd9, 6'h20), 32'h0000_0100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_rs_data !== 32'h1234_5678 || d_o_rt_data !== 32'h1234_5678 ||
            d_o_ctrl !== 7'b1000001 || d_o_dst_addr !== 5'd9 || d_o_ce !== 1'b1 ||
            d_o_funct !== 6'h20 || d_o_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL rtype_add: rs=%h rt=%h ctrl=%b dst=%0d ce=%0b fn=%h pc=%h want 12345678 12345678 1000001 9 1 20 100",
                     d_o_rs_data, d_o_rt_data, d_o_ctrl, d_o_dst_addr, d_o_ce, d_o_funct, d_o_pc);
        end
    endtask

    task automatic test_bypass;
        drive(1'b1, i_type(6'h23, 5'd3, 5'd4, 16'hFFFC), 32'h0000_0104, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (d_o_rs_data !== 32'hDEAD_BEEF || d_o_imm !== 32'hFFFF_FFFC ||
            d_o_ctrl !== 7'b1101000 || d_o_dst_addr !== 5'd4) begin
            errors++;
            $display("FAIL bypass_lw: rs=%h imm=%h ctrl=%b dst=%0d want deadbeef fffffffc 1101000 4",
                     d_o_rs_data, d_o_imm, d_o_ctrl, d_o_dst_addr);
        end
    endtask

    task automatic test_r0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        // read r0 while also attempting a same-cycle write to r0
        drive(1'b1, r_type(5'd0, 5'd0, 5'd1, 6'h20), 32'h0000_0108, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (d_o_rs_data !== 32'h0 || d_o_rt_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_zero: rs=%h rt=%h want 0 0", d_o_rs_data, d_o_rt_data);
        end
    endtask

    task automatic test_jump;
        drive(1'b1, {6'h02, 26'h0000040}, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (d_o_change_pc !== 1'b1 || d_o_pc_target !== 32'h0000_0100) begin
            errors++;
            $display("FAIL jump_redirect: change=%0b target=%h want 1 00000100", d_o_change_pc, d_o_pc_target);
        end
        tick();
        checks++;
        if (d_o_ce !== 1'b0 || d_o_ctrl !== 7'b0) begin
            errors++;
            $display("FAIL jump_bubble: ce=%0b ctrl=%b want 0 0", d_o_ce, d_o_ctrl);
        end
        idle();
        #1;
        checks++;
        if (d_o_change_pc !== 1'b0 || d_o_pc_target !== 32'h0) begin
            errors++;
            $display("FAIL jump_pulse_end: change=%0b target=%h want 0 0", d_o_change_pc, d_o_pc_target);
        end
        // pc+4 wraps to zero at the top of the address space
        drive(1'b1, {6'h02, 26'h3FF_FFFF}, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (d_o_change_pc !== 1'b1 || d_o_pc_target !== 32'h0FFF_FFFC) begin
            errors++;
            $display("FAIL jump_wrap: change=%0b target=%h want 1 0ffffffc", d_o_change_pc, d_o_pc_target);
        end
        d_i_stall = 1'b1;
        #1;
        checks++;
        if (d_o_change_pc !== 1'b0) begin
            errors++;
            $display("FAIL jump_stalled: change=%0b want 0", d_o_change_pc);
        end
        tick();
    endtask

    task automatic test_stall_flush;
        logic [31:0] snap_pc, snap_rs, snap_imm;
        logic [6:0]  snap_ctrl;
        logic [4:0]  snap_dst;
        drive(1'b1, i_type(6'h08, 5'd8, 5'd12, 16'h8001), 32'h0000_2000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        snap_pc = 32'h0000_2000; snap_rs = mregs[8]; snap_imm = 32'hFFFF_8001;
        snap_ctrl = 7'b1001000;  snap_dst = 5'd12;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, r_type(5'(i + 1), 5'(i + 2), 5'(i + 3), 6'h22), 32'h0000_3000 + 32'(i * 4),
                  1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            tick();
            checks++;
            if (d_o_ce !== 1'b1 || d_o_pc !== snap_pc || d_o_rs_data !== snap_rs ||
                d_o_imm !== snap_imm || d_o_ctrl !== snap_ctrl || d_o_dst_addr !== snap_dst) begin
                errors++;
                $display("FAIL stall_hold_%0d: ce=%0b pc=%h rs=%h imm=%h ctrl=%b dst=%0d want 1 %h %h %h %b %0d",
                         i, d_o_ce, d_o_pc, d_o_rs_data, d_o_imm, d_o_ctrl, d_o_dst_addr,
                         snap_pc, snap_rs, snap_imm, snap_ctrl, snap_dst);
            end
        end
        drive(1'b1, r_type(5'd1, 5'd2, 5'd3, 6'h20), 32'h0000_4000, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_ce !== 1'b0 || d_o_ctrl !== 7'b0 || d_o_dst_addr !== 5'd0) begin
            errors++;
            $display("FAIL flush_stall: ce=%0b ctrl=%b dst=%0d want 0 0 0", d_o_ce, d_o_ctrl, d_o_dst_addr);
        end
    endtask

    task automatic test_random;
        logic [5:0]  ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [5:0]  op;
        logic [31:0] instr, pc;
        logic        exp_chg;
        logic [31:0] exp_tgt;
        int          bad_comb, bad_reg;
        bad_comb = 0;
        bad_reg  = 0;
        for (int n = 0; n < 300; n++) begin
            op    = ops[$urandom_range(0, 6)];
            instr = {op, 26'($urandom)};
            pc    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            drive($urandom_range(0, 4) != 0, instr, pc,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            #1;
            exp_chg = d_i_ce && op == 6'h02 && !d_i_stall;
            exp_tgt = d_i_ce ? (((pc + 32'd4) & 32'hF000_0000) | (32'(instr[25:0]) * 4)) : 32'h0;
            checks++;
            if (d_o_change_pc !== exp_chg || d_o_pc_target !== exp_tgt) begin
                errors++;
                bad_comb++;
                if (bad_comb <= 5)
                    $display("FAIL rand_comb_%0d: change=%0b target=%h want %0b %h",
                             n, d_o_change_pc, d_o_pc_target, exp_chg, exp_tgt);
            end
            tick();
            checks++;
            if (d_o_ce !== exp_q.ce || d_o_ctrl !== exp_q.ctrl || d_o_illegal !== exp_q.illegal ||
                (dst_known && d_o_dst_addr !== exp_q.dst) ||
                (data_known && {d_o_pc, d_o_rs_data, d_o_rt_data, d_o_imm, d_o_rs_addr, d_o_rt_addr, d_o_funct} !==
                               {exp_q.pc, exp_q.rs, exp_q.rt, exp_q.imm, exp_q.rsa, exp_q.rta, exp_q.funct})) begin
                errors++;
                bad_reg++;
                if (bad_reg <= 5)
                    $display("FAIL rand_idex_%0d: ce=%0b ctrl=%b dst=%0d rs=%h rt=%h imm=%h want %0b %b %0d %h %h %h",
                             n, d_o_ce, d_o_ctrl, d_o_dst_addr, d_o_rs_data, d_o_rt_data, d_o_imm,
                             exp_q.ce, exp_q.ctrl, exp_q.dst, exp_q.rs, exp_q.rt, exp_q.imm);
            end
        end
        idle();
    endtask

    task automatic test_illegal;
        drive(1'b1, {6'h3F, 26'h123_4567}, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_illegal !== 1'b1 || d_o_ce !== 1'b0 || d_o_ctrl !== 7'b0) begin
            errors++;
            $display("FAIL illegal_op: illegal=%0b ce=%0b ctrl=%b want 1 0 0", d_o_illegal, d_o_ce, d_o_ctrl);
        end
        drive(1'b1, i_type(6'h08, 5'd1, 5'd2, 16'h0003), 32'h0000_5004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (d_o_illegal !== 1'b1 || d_o_ce !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: illegal=%0b ce=%0b want 1 1", d_o_illegal, d_o_ce);
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_bypass();
        test_r0();
        test_jump();
        test_stall_flush();
        test_random();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
